pll_reset_sequencer: RTL and testbench

Sequences the on-chip rPLL and the reset tree behind it. Runs on the free-running 27 MHz board clock, pulses the PLL `RESET`, waits for a stable `lock`, then releases core and peripheral resets in order. On lock loss it re-asserts all resets and re-arms the PLL; after repeated lock timeouts it latches a failure flag. Sits between the top level, the rPLL wrapper and every clocked subsystem.

---
 rtl/pll_seq_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
//   pll_seq_state_t : sequencer FSM states
//   cnt_width()     : width of a counter that must reach the largest cycle parameter
//   Def*            : default cycle constants for a 27 MHz reference clock
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRelCore,
    StRun,
    StFail
  } pll_seq_state_t;

  localparam int unsigned DefPllRstCyc     = 27;     // 1 us
  localparam int unsigned DefLockTimeoutCyc = 27000; // 1 ms
  localparam int unsigned DefLockStableCyc = 2700;   // 100 us
  localparam int unsigned DefStageGapCyc   = 16;
  localparam int unsigned DefMaxRetry      = 3;

  // The counter only ever counts up to (largest parameter - 1).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level signals.
//   i_clk   : destination clock
//   i_rst_n : synchronous active-low reset, flops clear to 0
//   i_d     : asynchronous input
//   o_q     : synchronized output (2 edges of latency)
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the rPLL reset and the reset tree behind it.
//   clkin        : free-running reference clock (only clock)
//   rst_n        : synchronous active-low reset
//   lock         : rPLL lock, asynchronous to clkin
//   restart      : single-cycle re-lock request
//   pll_reset    : rPLL RESET, active-high
//   core_rst_n   : core reset, released first
//   periph_rst_n : peripheral reset, released STAGE_GAP_CYC after core
//   ready        : high only in RUN
//   fail         : sticky lock failure, cleared by restart or rst_n
//   lost_cnt     : saturating count of lock losses seen in REL_CORE/RUN
// All outputs are registered and decoded from the next state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC      = DefPllRstCyc,
  parameter int unsigned LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
  parameter int unsigned LOCK_STABLE_CYC  = DefLockStableCyc,
  parameter int unsigned STAGE_GAP_CYC    = DefStageGapCyc,
  parameter int unsigned MAX_RETRY        = DefMaxRetry
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       core_rst_n,
  output logic       periph_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lost_cnt
);

  localparam int unsigned CntW =
      cnt_width(PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC, STAGE_GAP_CYC);
  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CntW-1:0]   PllRstLast  = CntW'(PLL_RST_CYC - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE_CYC - 1);
  localparam logic [CntW-1:0]   GapLast     = CntW'(STAGE_GAP_CYC - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);

  logic w_lock_s;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .i_clk  (clkin),
    .i_rst_n(rst_n),
    .i_d    (lock),
    .o_q    (w_lock_s)
  );

  pll_seq_state_t    r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [RetryW-1:0] r_retry, w_retry_d;
  logic [7:0]        r_lost_cnt, w_lost_cnt_d;
  logic              w_lost;
  logic              r_pll_reset, r_core_rst_n, r_periph_rst_n, r_ready, r_fail;

  // Next-state: restart beats lock loss, lock loss beats counter expiry.
  always_comb begin
    w_state_d = r_state;
    w_retry_d = r_retry;
    w_lost    = 1'b0;
    if (restart) begin
      w_state_d = StPllRst;
      w_retry_d = '0;
    end else begin
      unique case (r_state)
        StPllRst: begin
          if (r_cnt == PllRstLast) w_state_d = StWaitLock;
        end
        StWaitLock: begin
          if (w_lock_s) begin
            w_state_d = StStable;
          end else if (r_cnt == TimeoutLast) begin
            if (r_retry == RetryMax) begin
              w_state_d = StFail;
            end else begin
              w_state_d = StPllRst;
              w_retry_d = r_retry + 1'b1;
            end
          end
        end
        StStable: begin
          if (!w_lock_s) w_state_d = StWaitLock;
          else if (r_cnt == StableLast) w_state_d = StRelCore;
        end
        StRelCore: begin
          if (!w_lock_s) begin
            w_state_d = StPllRst;
            w_retry_d = '0;
            w_lost    = 1'b1;
          end else if (r_cnt == GapLast) begin
            w_state_d = StRun;
          end
        end
        StRun: begin
          w_retry_d = '0;
          if (!w_lock_s) begin
            w_state_d = StPllRst;
            w_lost    = 1'b1;
          end
        end
        StFail: begin
          w_state_d = StFail;
        end
        default: begin
          w_state_d = StPllRst;
        end
      endcase
    end

    // Restart clears the counter even from PLLRST so the pulse is always full length.
    // RUN and FAIL never compare the counter, so it is parked there.
    if (restart || (w_state_d != r_state)) begin
      w_cnt_d = '0;
    end else if ((r_state == StRun) || (r_state == StFail)) begin
      w_cnt_d = r_cnt;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end

    w_lost_cnt_d = r_lost_cnt;
    if (w_lost && (r_lost_cnt != 8'hFF)) w_lost_cnt_d = r_lost_cnt + 8'd1;
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_state        <= StPllRst;
      r_cnt          <= '0;
      r_retry        <= '0;
      r_lost_cnt     <= '0;
      r_pll_reset    <= 1'b1;
      r_core_rst_n   <= 1'b0;
      r_periph_rst_n <= 1'b0;
      r_ready        <= 1'b0;
      r_fail         <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_retry        <= w_retry_d;
      r_lost_cnt     <= w_lost_cnt_d;
      r_pll_reset    <= (w_state_d == StPllRst);
      r_core_rst_n   <= (w_state_d == StRelCore) || (w_state_d == StRun);
      r_periph_rst_n <= (w_state_d == StRun);
      r_ready        <= (w_state_d == StRun);
      r_fail         <= (w_state_d == StFail);
    end
  end

  assign pll_reset    = r_pll_reset;
  assign core_rst_n   = r_core_rst_n;
  assign periph_rst_n = r_periph_rst_n;
  assign ready        = r_ready;
  assign fail         = r_fail;
  assign lost_cnt     = r_lost_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, core_rst_n, periph_rst_n, ready, fail;
  logic [7:0] lost_cnt;
  logic [12:0] outv;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [12:0] exp;
  } sb_t;

  sb_t sb[$];

  pll_reset_sequencer #(
    .PLL_RST_CYC     (4),
    .LOCK_TIMEOUT_CYC(20),
    .LOCK_STABLE_CYC (8),
    .STAGE_GAP_CYC   (3),
    .MAX_RETRY       (2)
  ) dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .lock        (lock),
    .restart     (restart),
    .pll_reset   (pll_reset),
    .core_rst_n  (core_rst_n),
    .periph_rst_n(periph_rst_n),
    .ready       (ready),
    .fail        (fail),
    .lost_cnt    (lost_cnt)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  assign outv = {pll_reset, core_rst_n, periph_rst_n, ready, fail, lost_cnt};

  function automatic logic [12:0] mk(input logic pr, input logic c, input logic p,
                                     input logic r, input logic f, input logic [7:0] l);
    return {pr, c, p, r, f, l};
  endfunction

  // Expected output vector after posedge number 'at', kept sorted by cycle.
  task automatic expect_at(input int at, input string tag, input logic [12:0] v);
    sb_t e;
    int  i;
    e.cyc = at;
    e.tag = tag;
    e.exp = v;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= at) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clkin) begin : chk
    sb_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      assert (outv === e.exp) passed++;
      else $error("FAIL %s cyc=%0d observed=%h expected=%h", e.tag, cyc, outv, e.exp);
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clkin);
    #2;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 500) begin
      adv(1);
      k++;
    end
    checks++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL drain observed=%0d pending expected=0", sb.size());
  endtask

  function automatic logic cur(input int which);
    return (which == 0) ? core_rst_n : pll_reset;
  endfunction

  task automatic wait_sig(input int which, input logic val, input int bound, input string tag);
    int   k;
    logic got;
    k   = 0;
    got = (cur(which) === val);
    while (!got && k < bound) begin
      adv(1);
      k++;
      got = (cur(which) === val);
    end
    checks++;
    assert (got === 1'b1) passed++;
    else $error("FAIL %s timeout observed=%b expected=%b", tag, cur(which), val);
  endtask

  initial begin
    int b;
    int l;
    logic [7:0] exp_lost;

    // Reset state, then exact PLL reset pulse and nominal release.
    adv(3);
    b = cyc;
    expect_at(b, "reset", mk(1, 0, 0, 0, 0, 0));
    expect_at(b + 1, "pllrst_hold1", mk(1, 0, 0, 0, 0, 0));
    expect_at(b + 3, "pllrst_hold4", mk(1, 0, 0, 0, 0, 0));
    expect_at(b + 4, "pllrst_fall", mk(0, 0, 0, 0, 0, 0));
    l = b + 9;  // lock rises 5 cycles after pll_reset falls
    expect_at(l + 10, "nom_core_pre", mk(0, 0, 0, 0, 0, 0));
    expect_at(l + 11, "nom_core_rel", mk(0, 1, 0, 0, 0, 0));
    expect_at(l + 13, "nom_periph_pre", mk(0, 1, 0, 0, 0, 0));
    expect_at(l + 14, "nom_run", mk(0, 1, 1, 1, 0, 0));
    rst_n = 1'b1;
    adv(9);
    lock = 1'b1;
    drain();

    // Lock loss in RUN, then re-lock with nominal timing.
    b = cyc;
    expect_at(b + 2, "loss_still_run", mk(0, 1, 1, 1, 0, 0));
    expect_at(b + 3, "loss_resets", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 6, "loss_pll_hold", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 7, "loss_pll_fall", mk(0, 0, 0, 0, 0, 1));
    l = b + 12;
    expect_at(l + 10, "relock_core_pre", mk(0, 0, 0, 0, 0, 1));
    expect_at(l + 11, "relock_core", mk(0, 1, 0, 0, 0, 1));
    expect_at(l + 14, "relock_run", mk(0, 1, 1, 1, 0, 1));
    lock = 1'b0;
    adv(12);
    lock = 1'b1;
    drain();

    // Restart in RUN, then a one-cycle lock glitch in the 4th STABLE cycle.
    b = cyc;
    expect_at(b + 1, "restart_run", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 4, "restart_pll_hold", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 5, "restart_pll_fall", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 14, "glitch_no_core", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 18, "glitch_core_pre", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 19, "glitch_core", mk(0, 1, 0, 0, 0, 1));
    expect_at(b + 22, "glitch_run", mk(0, 1, 1, 1, 0, 1));
    restart = 1'b1;
    adv(1);
    restart = 1'b0;
    adv(6);
    lock = 1'b0;
    adv(1);
    lock = 1'b1;
    drain();

    // rst_n asserted mid-STABLE clears lost_cnt; recovery after release.
    b = cyc;
    expect_at(b + 7, "stable_pre_rst", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 9, "rst_mid_stable", mk(1, 0, 0, 0, 0, 0));
    expect_at(b + 10, "rst_held", mk(1, 0, 0, 0, 0, 0));
    expect_at(b + 13, "rst_rel_pll_hold", mk(1, 0, 0, 0, 0, 0));
    expect_at(b + 14, "rst_rel_pll_fall", mk(0, 0, 0, 0, 0, 0));
    expect_at(b + 22, "rst_rel_core_pre", mk(0, 0, 0, 0, 0, 0));
    expect_at(b + 23, "rst_rel_core", mk(0, 1, 0, 0, 0, 0));
    expect_at(b + 26, "rst_rel_run", mk(0, 1, 1, 1, 0, 0));
    restart = 1'b1;
    adv(1);
    restart = 1'b0;
    adv(7);
    rst_n = 1'b0;
    adv(2);
    rst_n = 1'b1;
    drain();

    // No lock: three PLL pulses, FAIL, then restart.
    b = cyc;
    expect_at(b + 3, "nolock_p1", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 6, "nolock_p1_end", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 7, "nolock_w1", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 26, "nolock_w1_end", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 27, "nolock_p2", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 30, "nolock_p2_end", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 31, "nolock_w2", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 50, "nolock_w2_end", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 51, "nolock_p3", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 54, "nolock_p3_end", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 55, "nolock_w3", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 74, "nolock_w3_end", mk(0, 0, 0, 0, 0, 1));
    expect_at(b + 75, "fail_set", mk(0, 0, 0, 0, 1, 1));
    expect_at(b + 80, "fail_sticky", mk(0, 0, 0, 0, 1, 1));
    expect_at(b + 81, "fail_restart", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 84, "fail_restart_hold", mk(1, 0, 0, 0, 0, 1));
    expect_at(b + 85, "fail_restart_fall", mk(0, 0, 0, 0, 0, 1));
    lock = 1'b0;
    adv(80);
    restart = 1'b1;
    adv(1);
    restart = 1'b0;
    drain();

    // Saturation: 256 more forced losses, each taken in REL_CORE.
    exp_lost = 8'd1;
    for (int i = 0; i < 256; i++) begin
      lock = 1'b1;
      wait_sig(0, 1'b1, 60, "sat_core_wait");
      lock = 1'b0;
      wait_sig(1, 1'b1, 20, "sat_pll_wait");
      if (exp_lost != 8'hFF) exp_lost = exp_lost + 8'd1;
      expect_at(cyc, "sat_lost", mk(1, 0, 0, 0, 0, exp_lost));
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
